// File: rtl/seq_divider32_pkg.sv
// Shared definitions for the sequential divider: FSM encoding, default width
// and the quotient value reported on a divide-by-zero.
package seq_divider32_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2
    } state_e;

    localparam logic [WIDTH_DEF-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider32_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the
// divisor magnitude, and keep the difference only when it does not borrow.
module seq_divider32_div_step
    import seq_divider32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        // MSB of the WIDTH+1-bit difference is the borrow: set means shifted < divisor.
        trial   = shifted - {1'b0, dvsr_i};
        quo_o   = {quo_i[WIDTH-2:0], ~trial[WIDTH]};
        rem_o   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider32.sv
// Iterative restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// fixed 34-cycle start-to-done latency, results held for HI (remainder) / LO (quotient).
module seq_divider32
    import seq_divider32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             cancel,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] DIV0_Q    = WIDTH'($signed(DIV0_QUOTIENT));

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        // -(-2^(W-1)) wraps back to 0x80..0, which is the correct unsigned magnitude.
        return (sgn && (sv < 0)) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    seq_divider32_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .quo_o  (step_quo)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        dividend_d  = dividend_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    dividend_d = dividend;
                    dvsr_d     = magnitude(divisor, is_signed);
                    quo_d      = magnitude(dividend, is_signed);
                    rem_d      = '0;
                    count_d    = '0;
                    q_neg_d    = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg_d    = is_signed & dividend[WIDTH-1];
                    state_d    = ST_CALC;
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d   = step_rem;
                    quo_d   = step_quo;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST_ITER) begin
                        state_d = ST_SIGN;
                    end
                end
            end
            ST_SIGN: begin
                state_d = ST_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    // Zero divisor still runs the full iteration count so latency never varies.
                    if (dvsr_q == '0) begin
                        quotient_d  = DIV0_Q;
                        remainder_d = dividend_q;
                        dbz_d       = 1'b1;
                    end else begin
                        quotient_d  = negate_if(quo_q, q_neg_q);
                        remainder_d = negate_if(rem_q, r_neg_q);
                        dbz_d       = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            dividend_q  <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            dividend_q  <= dividend_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
